// File: rtl/dmem_pkg.sv
// Shared defaults and types for the data memory.
package dmem_pkg;
  localparam int XLEN_DEF  = 64;
  localparam int DEPTH_DEF = 128;
  localparam int ADDR_LSB  = $clog2(XLEN_DEF / 8);
  localparam int INDEX_W   = $clog2(DEPTH_DEF);
  localparam int BYTES     = DEPTH_DEF * XLEN_DEF / 8;

  typedef logic [XLEN_DEF-1:0] word_t;
endpackage

// File: rtl/dmem_addr_decode.sv
// Byte address to word index, plus optional validity check.
// DMEM_RANGE_CHECK_EN enables bounds and alignment checking.
module dmem_addr_decode
  import dmem_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic [XLEN-1:0]          address,
  output logic [$clog2(DEPTH)-1:0] index,
  output logic                     valid
);
  localparam int LSB = $clog2(XLEN / 8);
  localparam int IW  = $clog2(DEPTH);
  localparam int NB  = DEPTH * (XLEN / 8);

  assign index = address[LSB +: IW];

`ifdef DMEM_RANGE_CHECK_EN
  logic in_range;
  logic aligned;

  assign in_range = address < XLEN'(NB);
  assign aligned  = address[LSB-1:0] == '0;
  assign valid    = in_range && aligned;
`else
  logic unused_bits;

  // Bits outside the index field are dropped so accesses wrap.
  assign unused_bits = ^{address[XLEN-1:LSB+IW], address[LSB-1:0]};
  assign valid       = 1'b1;
`endif
endmodule

// File: rtl/data_mem.sv
// Word-organised data memory: sync write, comb read, async clear.
// DMEM_RANGE_CHECK_EN adds the range_err output.
module data_mem
  import dmem_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] write_data,
  input  logic            write_en,
  input  logic            read_en,
`ifdef DMEM_RANGE_CHECK_EN
  output logic            range_err,
`endif
  output logic [XLEN-1:0] read_data
);
  localparam int IW = $clog2(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [IW-1:0]   index;
  logic            valid;

  dmem_addr_decode #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_decode (
    .address (address),
    .index   (index),
    .valid   (valid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_en && valid) begin
      mem[index] <= write_data;
    end
  end

  assign read_data = (read_en && valid) ? mem[index] : '0;

`ifdef DMEM_RANGE_CHECK_EN
  assign range_err = (read_en || write_en) && !valid;
`endif
endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem.
module tb_data_mem;
  import dmem_pkg::*;

  logic  clk;
  logic  rstn;
  word_t address;
  word_t write_data;
  logic  write_en;
  logic  read_en;
  word_t read_data;
`ifdef DMEM_RANGE_CHECK_EN
  logic  range_err;
`endif

  int tests;
  int fails;

  data_mem dut (
    .clk        (clk),
    .rstn       (rstn),
    .address    (address),
    .write_data (write_data),
    .write_en   (write_en),
    .read_en    (read_en),
`ifdef DMEM_RANGE_CHECK_EN
    .range_err  (range_err),
`endif
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input word_t got,
    input word_t exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic rd(
    input string tag,
    input word_t a,
    input word_t exp
  );
    address = a;
    #1;
    check(tag, read_data, exp);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rstn       = 1'b0;
    write_en   = 1'b1;
    read_en    = 1'b1;
    address    = 64'd8;
    write_data = 64'd5;

    // write held during reset must not land
    @(posedge clk);
    @(negedge clk);
    write_en = 1'b0;
    for (int n = 0; n < 128; n++) begin
      rd("rst_clear", word_t'(8 * n), '0);
    end

    // release between edges with the write still held
    @(negedge clk);
    address    = 64'd8;
    write_data = 64'd5;
    write_en   = 1'b1;
    #1;
    rstn = 1'b1;
    #1;
    check("pre_edge", read_data, '0);
    @(posedge clk);
    #1;
    check("post_rel", read_data, 64'd5);

    // read gating with no clock edge
    @(negedge clk);
    write_en = 1'b0;
    read_en  = 1'b0;
    #1;
    check("gate_off", read_data, '0);
    read_en = 1'b1;
    #1;
    check("gate_on", read_data, 64'd5);

    // full sweep
    for (int n = 0; n < 128; n++) begin
      @(negedge clk);
      address    = word_t'(8 * n);
      write_data = word_t'(n);
      write_en   = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    write_en = 1'b0;
    for (int n = 0; n < 128; n++) begin
      rd("sweep", word_t'(8 * n), word_t'(n));
      #4;
    end

    // simultaneous read and write
    @(negedge clk);
    address    = 64'd16;
    write_data = 64'hAA;
    write_en   = 1'b1;
    #1;
    check("rw_old", read_data, 64'd2);
    @(posedge clk);
    #1;
    check("rw_new", read_data, 64'hAA);

    // full-width data
    @(negedge clk);
    address    = 64'd40;
    write_data = 64'hDEAD_BEEF_0123_4567;
    @(posedge clk);
    @(negedge clk);
    write_en = 1'b0;
    rd("wide", 64'd40, 64'hDEAD_BEEF_0123_4567);

`ifdef DMEM_RANGE_CHECK_EN
    @(negedge clk);
    address    = 64'd1024;
    write_data = 64'h33;
    write_en   = 1'b1;
    #1;
    check("oob_err", word_t'(range_err), 64'd1);
    @(posedge clk);
    @(negedge clk);
    address = 64'd9;
    write_data = 64'h44;
    #1;
    check("mis_err", word_t'(range_err), 64'd1);
    @(posedge clk);
    @(negedge clk);
    write_en = 1'b0;
    rd("oob_drop", 64'd0, 64'd0);
    rd("mis_drop", 64'd8, 64'd1);
    rd("oob_rd", 64'd1024, '0);
    rd("mis_rd", 64'd9, '0);
    #1;
    check("mis_rerr", word_t'(range_err), 64'd1);
    rd("ok_rd", 64'd24, 64'd3);
    check("ok_err", word_t'(range_err), 64'd0);
`else
    // upper bits wrap, low bits ignored
    @(negedge clk);
    address    = 64'd1048;
    write_data = 64'h33;
    write_en   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    write_en = 1'b0;
    rd("wrap", 64'd24, 64'h33);
    rd("low_bits", 64'd27, 64'h33);
    rd("hi_alias", 64'h8000_0000_0000_0018, 64'h33);
`endif

    // mid-run async reset between edges
    @(negedge clk);
    #2;
    rstn = 1'b0;
    for (int n = 0; n < 128; n++) begin
      rd("mid_rst", word_t'(8 * n), '0);
    end
    rstn = 1'b1;
    #1;
    rd("after_rst", 64'd16, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
